sram_seq_ctrl: RTL

Sequencer for the FFT sample buffer (`sram_system`: one 128-deep long bank and three 32-deep short banks, 4 lanes each, real and imaginary). It accepts one producer frame (128 long-bank beats, then 96 short-bank beats) and drives all write enables, bank selects and addresses. It then replays the frame to a consumer in bank order or transposed order. Write data flows straight from producer to the memory; the controller owns only control and addresses.

---
 rtl/fft_mem_pkg.sv | 38 +++
 rtl/sram_seq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_mem_pkg.sv
// Shared definitions for the FFT sample buffer and its sequencer.
// Address widths match sram_system: one 128-deep long bank and three
// 32-deep short banks. Also holds the sequencer state encoding, the
// bank/read-select encodings and the per-frame beat counts.
package fft_mem_pkg;

    localparam int unsigned ADDR_L_WIDTH = 7;
    localparam int unsigned ADDR_S_WIDTH = 5;
    localparam int unsigned CNT_WIDTH    = 7;

    localparam int unsigned LONG_BEATS  = 128;
    localparam int unsigned SHORT_BEATS = 96;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_L = 3'd1,
        ST_LOAD_S = 3'd2,
        ST_READ_L = 3'd3,
        ST_READ_S = 3'd4,
        ST_READ_X = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_e;

    // Write bank select
    localparam logic [1:0] CS_LONG   = 2'b00;
    localparam logic [1:0] CS_SHORT1 = 2'b01;
    localparam logic [1:0] CS_SHORT2 = 2'b10;
    localparam logic [1:0] CS_SHORT3 = 2'b11;

    // Read select: 0BB = bank BB, 1LL = cross-bank lane LL
    localparam logic [2:0] CS_RD_LONG   = 3'b000;
    localparam logic [2:0] CS_RD_SHORT1 = 3'b001;
    localparam logic [2:0] CS_XLANE0    = 3'b100;
    localparam logic [2:0] CS_XLANE1    = 3'b101;
    localparam logic [2:0] CS_XLANE2    = 3'b110;
    localparam logic [2:0] CS_XLANE3    = 3'b111;

endpackage

// File: rtl/sram_seq_ctrl.sv
// Sequencer for the FFT sample buffer. Accepts one producer frame
// (128 long-bank beats then 96 short-bank beats), driving write enables,
// bank select and write address; then replays the frame to a consumer in
// bank order (mode 0) or transposed cross-bank order (mode 1).
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i, mode_i          frame start pulse, readback order (latched at start)
//   abort_i                  synchronous return to IDLE, blocks wen_o at once
//   in_valid_i / in_ready_o  producer handshake
//   rd_ready_i               consumer permits a read issue this cycle
//   rd_valid_o, rd_last_o    read data valid (one cycle after issue), last beat
//   wen_o, cs_wr_o, addr_wr_o  write enables, write bank select, write address
//   cs_rd_o, addr_rd_o       read select, read address
//   busy_o, done_o           frame in progress, completion pulse
module sram_seq_ctrl
    import fft_mem_pkg::*;
#(
    parameter int unsigned AddrLWidth = ADDR_L_WIDTH,
    parameter int unsigned AddrSWidth = ADDR_S_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic                  abort_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  rd_ready_i,
    output logic                  rd_valid_o,
    output logic                  rd_last_o,
    output logic [3:0]            wen_o,
    output logic [1:0]            cs_wr_o,
    output logic [AddrLWidth-1:0] addr_wr_o,
    output logic [2:0]            cs_rd_o,
    output logic [AddrLWidth-1:0] addr_rd_o,
    output logic                  busy_o,
    output logic                  done_o
);

    seq_state_e           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_mode;
    // [0] read valid, [1] read last: one-cycle delay of the issue
    logic [1:0]           r_rd_pipe;

    logic       w_wr_beat;
    logic       w_rd_issue;
    logic       w_term;
    logic       w_last_issue;
    logic [1:0] w_short_cs;
    logic [2:0] w_xlane;

    always_comb begin
        case (r_cnt[AddrSWidth +: 2])
            2'd0:    w_short_cs = CS_SHORT1;
            2'd1:    w_short_cs = CS_SHORT2;
            default: w_short_cs = CS_SHORT3;
        endcase

        case (r_cnt[1:0])
            2'd0:    w_xlane = CS_XLANE0;
            2'd1:    w_xlane = CS_XLANE1;
            2'd2:    w_xlane = CS_XLANE2;
            default: w_xlane = CS_XLANE3;
        endcase

        case (r_state)
            ST_LOAD_S, ST_READ_S: w_term = (r_cnt == CNT_WIDTH'(SHORT_BEATS - 1));
            default:              w_term = (r_cnt == CNT_WIDTH'(LONG_BEATS - 1));
        endcase

        w_wr_beat    = in_valid_i && (r_state == ST_LOAD_L || r_state == ST_LOAD_S);
        w_rd_issue   = rd_ready_i && (r_state == ST_READ_L || r_state == ST_READ_S ||
                                      r_state == ST_READ_X);
        w_last_issue = w_rd_issue && w_term && (r_state == ST_READ_S || r_state == ST_READ_X);
    end

    // Write path and read addressing are combinational from state/cnt so the
    // memory captures on the same edge as the handshake.
    always_comb begin
        wen_o      = '0;
        cs_wr_o    = CS_LONG;
        addr_wr_o  = '0;
        cs_rd_o    = CS_RD_LONG;
        addr_rd_o  = '0;
        in_ready_o = 1'b0;
        case (r_state)
            ST_LOAD_L: begin
                in_ready_o = 1'b1;
                addr_wr_o  = AddrLWidth'(r_cnt);
                // Read and write share address muxes; park read select off the long bank
                cs_rd_o    = CS_RD_SHORT1;
                if (in_valid_i && !abort_i) begin
                    wen_o = 4'b0001;
                end
            end
            ST_LOAD_S: begin
                in_ready_o = 1'b1;
                cs_wr_o    = w_short_cs;
                addr_wr_o  = AddrLWidth'(r_cnt[AddrSWidth-1:0]);
                cs_rd_o    = CS_RD_LONG;
                if (in_valid_i && !abort_i) begin
                    wen_o = 4'b0001 << w_short_cs;
                end
            end
            ST_READ_L: begin
                cs_rd_o   = CS_RD_LONG;
                addr_rd_o = AddrLWidth'(r_cnt);
            end
            ST_READ_S: begin
                cs_rd_o   = {1'b0, w_short_cs};
                addr_rd_o = AddrLWidth'(r_cnt[AddrSWidth-1:0]);
            end
            ST_READ_X: begin
                cs_rd_o   = w_xlane;
                addr_rd_o = AddrLWidth'(r_cnt[CNT_WIDTH-1:2]);
            end
            default: ;
        endcase

        busy_o     = (r_state != ST_IDLE);
        done_o     = (r_state == ST_DONE);
        rd_valid_o = r_rd_pipe[0];
        rd_last_o  = r_rd_pipe[1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_rd_pipe <= '0;
        end else if (abort_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe <= {w_last_issue, w_rd_issue};
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_mode  <= mode_i;
                        r_cnt   <= '0;
                        r_state <= ST_LOAD_L;
                    end
                end
                ST_LOAD_L: begin
                    if (w_wr_beat) begin
                        if (w_term) begin
                            r_cnt   <= '0;
                            r_state <= ST_LOAD_S;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD_S: begin
                    if (w_wr_beat) begin
                        if (w_term) begin
                            r_cnt   <= '0;
                            r_state <= r_mode ? ST_READ_X : ST_READ_L;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_READ_L: begin
                    if (w_rd_issue) begin
                        if (w_term) begin
                            r_cnt   <= '0;
                            r_state <= ST_READ_S;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_READ_S, ST_READ_X: begin
                    if (w_rd_issue) begin
                        if (w_term) begin
                            r_cnt   <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
